// File: rtl/tone_detect.sv
// tone_detect: measures the full period of an external square wave and
// classifies it as 440 Hz, 880 Hz or neither.
//
// The pin is brought into the osc_CLK domain with a two-flop synchronizer,
// followed by a registered rising-edge detect. Each accepted rising edge
// closes one period measurement. An edge that comes too soon after the last
// accepted edge is treated as a glitch. If no edge arrives for MAX_PERIOD
// cycles, the block reports loss of signal.
//
// Ports:
//   osc_CLK        in   system clock (50 MHz nominal)
//   rst            in   asynchronous, active-high reset
//   pin_in         in   asynchronous square-wave input
//   period         out  last accepted full period, in clocks
//   period_valid   out  one-cycle strobe when period/tone_id update
//   tone_id        out  0 = none, 1 = 440 Hz, 2 = 880 Hz
//   tone_locked    out  LOCK_COUNT consecutive periods of the same class
//   signal_present out  high while a period is being measured
//   timeout        out  one-cycle strobe on loss of signal
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no signal; waiting for a starting edge, cnt held at 0
// MEASURE | counting clocks since the last accepted rising edge

module tone_detect #(
  parameter int P440       = 113636,
  parameter int P880       = 56818,
  parameter int TOL        = 1136,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = 8388607,
  parameter int LOCK_COUNT = 4
) (
  input  logic        osc_CLK,
  input  logic        rst,
  input  logic        pin_in,
  output logic [23:0] period,
  output logic        period_valid,
  output logic [1:0]  tone_id,
  output logic        tone_locked,
  output logic        signal_present,
  output logic        timeout
);

  localparam logic [23:0] MIN_W  = 24'(MIN_PERIOD);
  localparam logic [23:0] MAX_W  = 24'(MAX_PERIOD);
  localparam logic [24:0] P440_W = 25'(P440);
  localparam logic [24:0] P880_W = 25'(P880);
  localparam logic [24:0] TOL_W  = 25'(TOL);
  localparam logic [7:0]  LOCK_W = 8'(LOCK_COUNT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, sync3_q, rise_q;
  logic [23:0] cnt_q;
  logic [23:0] period_q;
  logic        period_valid_q;
  logic [1:0]  tone_id_q;
  logic        tone_locked_q;
  logic        signal_present_q;
  logic        timeout_q;
  logic [7:0]  lock_cnt_q;

  logic [24:0] cnt_ext;
  logic [24:0] dev440, dev880;
  logic [1:0]  class_d;
  logic [7:0]  lock_d;

  // sync3_q holds the previous synchronized level so that rise_q is a
  // single-cycle pulse three clocks after the pin goes high.
  always_ff @(posedge osc_CLK or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  // Classification of the count that is about to be accepted as the period.
  // The absolute deviation is taken in 25 bits so that the subtraction never wraps.
  assign cnt_ext = {1'b0, cnt_q};

  always_comb begin
    dev440 = (cnt_ext >= P440_W) ? (cnt_ext - P440_W) : (P440_W - cnt_ext);
    dev880 = (cnt_ext >= P880_W) ? (cnt_ext - P880_W) : (P880_W - cnt_ext);
    if (dev440 <= TOL_W) begin
      class_d = 2'd1;
    end else if (dev880 <= TOL_W) begin
      class_d = 2'd2;
    end else begin
      class_d = 2'd0;
    end
  end

  // A run of the same nonzero class extends the lock count. Any other class
  // restarts the count at 1 for a real tone and at 0 for "none".
  always_comb begin
    if ((class_d != 2'd0) && (class_d == tone_id_q)) begin
      lock_d = (lock_cnt_q >= LOCK_W) ? LOCK_W : (lock_cnt_q + 8'd1);
    end else begin
      lock_d = {7'd0, (class_d != 2'd0)};
    end
  end

  always_ff @(posedge osc_CLK or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      period_q         <= '0;
      period_valid_q   <= 1'b0;
      tone_id_q        <= 2'd0;
      tone_locked_q    <= 1'b0;
      signal_present_q <= 1'b0;
      timeout_q        <= 1'b0;
      lock_cnt_q       <= '0;
    end else begin
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise_q) begin
            cnt_q            <= 24'd1;
            state_q          <= MEASURE;
            signal_present_q <= 1'b1;
          end
        end
        MEASURE: begin
          // The edge is checked before the timeout, so an edge arriving
          // exactly at MAX_PERIOD is still accepted as a period.
          if (rise_q && (cnt_q >= MIN_W)) begin
            period_q       <= cnt_q;
            cnt_q          <= 24'd1;
            period_valid_q <= 1'b1;
            tone_id_q      <= class_d;
            lock_cnt_q     <= lock_d;
            tone_locked_q  <= (lock_d == LOCK_W);
          end else if (cnt_q >= MAX_W) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            timeout_q        <= 1'b1;
            signal_present_q <= 1'b0;
            tone_locked_q    <= 1'b0;
            lock_cnt_q       <= '0;
            tone_id_q        <= 2'd0;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign period         = period_q;
  assign period_valid   = period_valid_q;
  assign tone_id        = tone_id_q;
  assign tone_locked    = tone_locked_q;
  assign signal_present = signal_present_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_tone_detect.sv
// Testbench for tone_detect. It uses scaled-down parameters so that whole
// periods, lock sequences and timeouts fit in a short run.
module tb_tone_detect;

  localparam int P440  = 600;
  localparam int P880  = 300;
  localparam int TOL   = 6;
  localparam int MINP  = 60;
  localparam int MAXP  = 1500;
  localparam int LOCKN = 4;

  logic        osc_CLK = 1'b0;
  logic        rst;
  logic        pin_in;
  logic [23:0] period;
  logic        period_valid;
  logic [1:0]  tone_id;
  logic        tone_locked;
  logic        signal_present;
  logic        timeout;

  tone_detect #(
    .P440(P440), .P880(P880), .TOL(TOL),
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .LOCK_COUNT(LOCKN)
  ) dut (
    .osc_CLK(osc_CLK),
    .rst(rst),
    .pin_in(pin_in),
    .period(period),
    .period_valid(period_valid),
    .tone_id(tone_id),
    .tone_locked(tone_locked),
    .signal_present(signal_present),
    .timeout(timeout)
  );

  always #5 osc_CLK = ~osc_CLK;

  int cyc = 0;
  always @(posedge osc_CLK) cyc = cyc + 1;

  typedef struct {
    int cyc;
    bit is_to;
    int per;
    int id;
    bit lk;
    bit sp;
  } ev_t;

  ev_t exp_q[$];
  ev_t dut_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model, driven by the cycle stamps of pin rising edges.
  bit m_active = 0;
  int m_last = 0;
  int m_prev_id = 0;
  int m_lock = 0;
  int m_period = 0;

  function automatic int classify(input int p);
    int d4, d8;
    d4 = (p > P440) ? p - P440 : P440 - p;
    d8 = (p > P880) ? p - P880 : P880 - p;
    if (d4 <= TOL) return 1;
    if (d8 <= TOL) return 2;
    return 0;
  endfunction

  // Emits the loss-of-signal event if it is due at or before cycle 'now'.
  function automatic void m_timeout_check(input int now);
    ev_t e;
    if (m_active && (m_last + 4 + MAXP <= now)) begin
      e.cyc = m_last + 4 + MAXP; e.is_to = 1; e.per = m_period;
      e.id = 0; e.lk = 0; e.sp = 0;
      exp_q.push_back(e);
      m_active = 0; m_prev_id = 0; m_lock = 0;
    end
  endfunction

  function automatic void m_edge(input int t);
    ev_t e;
    int gap, id;
    m_timeout_check(t + 3);
    if (!m_active) begin
      m_active = 1;
      m_last = t;
    end else begin
      gap = t - m_last;
      if (gap >= MINP) begin
        id = classify(gap);
        if (id != 0 && id == m_prev_id) m_lock = (m_lock < LOCKN) ? m_lock + 1 : LOCKN;
        else m_lock = (id != 0) ? 1 : 0;
        e.cyc = t + 4; e.is_to = 0; e.per = gap; e.id = id;
        e.lk = (m_lock == LOCKN); e.sp = 1;
        exp_q.push_back(e);
        m_prev_id = id; m_period = gap; m_last = t;
      end
    end
  endfunction

  function automatic void m_reset();
    m_active = 0; m_last = 0; m_prev_id = 0; m_lock = 0; m_period = 0;
  endfunction

  always @(negedge osc_CLK) begin
    ev_t e;
    if (!rst && (period_valid || timeout)) begin
      e.cyc = cyc; e.is_to = timeout; e.per = int'(period); e.id = int'(tone_id);
      e.lk = tone_locked; e.sp = signal_present;
      dut_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_events(input string tag);
    ev_t a, e;
    @(negedge osc_CLK);
    #1;
    m_timeout_check(cyc);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      tests++;
      e = exp_q.pop_front();
      if (dut_q.size() == 0) begin
        fails++;
        $display("FAIL %s missing event: got none, expected to=%0d cyc=%0d per=%0d id=%0d lk=%0d",
                 tag, e.is_to, e.cyc, e.per, e.id, e.lk);
      end else begin
        a = dut_q.pop_front();
        if (a.cyc != e.cyc || a.is_to != e.is_to || a.per != e.per || a.id != e.id ||
            a.lk != e.lk || a.sp != e.sp) begin
          fails++;
          $display("FAIL %s event: got to=%0d cyc=%0d per=%0d id=%0d lk=%0d sp=%0d, expected to=%0d cyc=%0d per=%0d id=%0d lk=%0d sp=%0d",
                   tag, a.is_to, a.cyc, a.per, a.id, a.lk, a.sp,
                   e.is_to, e.cyc, e.per, e.id, e.lk, e.sp);
        end
      end
    end
    while (dut_q.size() > 0) begin
      tests++; fails++;
      a = dut_q.pop_front();
      $display("FAIL %s unexpected event: got to=%0d cyc=%0d per=%0d id=%0d, expected none",
               tag, a.is_to, a.cyc, a.per, a.id);
    end
  endtask

  task automatic set_pin(input logic v);
    @(posedge osc_CLK);
    #1;
    if (v && !pin_in) m_edge(cyc);
    pin_in = v;
  endtask

  task automatic seg(input logic v, input int n);
    repeat (n) set_pin(v);
  endtask

  task automatic pulse(input int hi, input int lo);
    seg(1'b1, hi);
    seg(1'b0, lo);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_period_valid"}, 32'(period_valid), 0);
    chk({tag, "_tone_id"}, 32'(tone_id), 0);
    chk({tag, "_tone_locked"}, 32'(tone_locked), 0);
    chk({tag, "_signal_present"}, 32'(signal_present), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  typedef struct {
    int hi;
    int lo;
    int nper;
    int exp_id;
    bit exp_lk;
  } vec_t;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    int gap, hi, prev_gap;
    vt[0] = '{300, 300, 5, 1, 1};
    vt[1] = '{150, 150, 5, 2, 1};
    vt[2] = '{300, 300, 5, 1, 1};
    vt[3] = '{297, 297, 5, 1, 1};
    vt[4] = '{303, 304, 5, 0, 0};
    vt[5] = '{303, 303, 5, 1, 1};
    vt[6] = '{147, 147, 5, 2, 1};
    vt[7] = '{153, 154, 5, 0, 0};
    vt[8] = '{400, 400, 5, 0, 0};

    rst = 1'b1;
    pin_in = 1'b0;
    #23;
    chk_all_zero("reset");
    @(posedge osc_CLK);
    #1 rst = 1'b0;

    // Idle with no input never times out.
    seg(1'b0, MAXP + 200);
    check_events("idle");
    chk_all_zero("idle");

    // Table of tone periods including class-band boundaries.
    for (int i = 0; i < 9; i++) begin
      for (int p = 0; p < vt[i].nper; p++) pulse(vt[i].hi, vt[i].lo);
      check_events($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_period", i), 32'(period), 32'(vt[i].hi + vt[i].lo));
      chk($sformatf("vec%0d_tone_id", i), 32'(tone_id), 32'(vt[i].exp_id));
      chk($sformatf("vec%0d_locked", i), 32'(tone_locked), 32'(vt[i].exp_lk));
      chk($sformatf("vec%0d_present", i), 32'(signal_present), 1);
    end

    // Lock on 440, then stop toggling.
    repeat (6) pulse(300, 300);
    check_events("lock");
    chk("lock_locked", 32'(tone_locked), 1);
    seg(1'b0, MAXP + 100);
    check_events("timeout");
    chk("to_present", 32'(signal_present), 0);
    chk("to_locked", 32'(tone_locked), 0);
    chk("to_tone_id", 32'(tone_id), 0);
    chk("to_period", 32'(period), 600);

    // Glitch 30 cycles after the starting edge inside a 600-cycle period.
    pulse(3, 27);
    pulse(3, 567);
    pulse(3, 597);
    pulse(30, 30);
    check_events("glitch");
    chk("glitch_period", 32'(period), 600);

    // MIN_PERIOD and MAX_PERIOD boundaries.
    pulse(1, MINP - 2);
    pulse(1, 1);
    pulse(1, MAXP - 1);
    pulse(1, MAXP - 1);
    pulse(1, MAXP);
    pulse(1, 10);
    check_events("bounds");
    chk("bounds_period", 32'(period), 32'(MAXP));
    seg(1'b0, MAXP + 100);
    check_events("bounds_to");

    // Reset asserted in the middle of a measurement.
    repeat (3) pulse(300, 300);
    seg(1'b1, 50);
    seg(1'b0, 100);
    check_events("pre_reset");
    #3 rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    m_reset();
    exp_q.delete();
    dut_q.delete();
    repeat (2) @(posedge osc_CLK);
    #1 rst = 1'b0;
    repeat (6) pulse(150, 150);
    check_events("post_reset");
    chk("post_reset_locked", 32'(tone_locked), 1);
    chk("post_reset_tone_id", 32'(tone_id), 2);

    // Randomized pulse trains.
    prev_gap = P440;
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 5))
        0: gap = P440 + int'($urandom_range(0, 30)) - 15;
        1: gap = P880 + int'($urandom_range(0, 30)) - 15;
        2: gap = int'($urandom_range(MINP - 10, 800));
        3: gap = int'($urandom_range(2, MINP));
        4: gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(MAXP - 1, MAXP + 2)) : P440;
        default: gap = prev_gap;
      endcase
      hi = int'($urandom_range(1, gap - 1));
      pulse(hi, gap - hi);
      prev_gap = gap;
      check_events($sformatf("rand%0d", r));
    end
    seg(1'b0, MAXP + 20);
    check_events("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_detect.md
Name: tone_detect

Overview:
- Receive-side counterpart to the square-wave tone/siren generator.
- Samples an external square wave on a pin and measures its full period in osc_CLK cycles.
- Classifies the period as 440 Hz, 880 Hz or neither, and flags a stable (locked) tone.
- Used for loopback self-test of the speaker output and for detecting tones from external sources.

Parameters:
- P440, 113636: nominal full period of 440 Hz in clocks (50 MHz/440).
- P880, 56818: nominal full period of 880 Hz in clocks.
- TOL, 1136: allowed ±deviation, in clocks, for a class match (about 1%).
- MIN_PERIOD, 1000: edges arriving sooner than this after the last accepted edge are glitches.
- MAX_PERIOD, 8388607: timeout (about 168 ms); must be below 2^24.
- LOCK_COUNT, 4: consecutive same-class periods required to assert tone_locked.

Ports:
- osc_CLK  in  1: system clock, 50 MHz.
- rst  in  1: asynchronous, active-high reset.
- pin_in  in  1: asynchronous square-wave input.
- period  out  24: last accepted full period, in clocks.
- period_valid  out  1: one-cycle strobe when period/tone_id update.
- tone_id  out  2: 0 = none, 1 = 440 Hz, 2 = 880 Hz; 3 is never driven.
- tone_locked  out  1: stable tone present.
- signal_present  out  1: in MEASURE state.
- timeout  out  1: one-cycle strobe on loss of signal.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - Synchronizer flops 0; state IDLE; cnt 0; lock_cnt 0.
- Input path:
  - Two-flop synchronizer, then a registered rising-edge detect.
  - rise is high for 1 cycle, 3 cycles after the pin_in 0→1 transition.
- State machine: IDLE, MEASURE.
- IDLE:
  - cnt held at 0.
  - On rise: cnt←1, go to MEASURE, signal_present←1. No period_valid on this first edge.
- MEASURE, no rise:
  - cnt←cnt+1.
  - If cnt==MAX_PERIOD: go to IDLE, cnt←0, timeout=1 for one cycle, signal_present←0, tone_locked←0, lock_cnt←0, tone_id←0.
  - period is retained through a timeout.
- MEASURE, rise with cnt<MIN_PERIOD:
  - Glitch: ignored entirely. cnt keeps incrementing; no output change.
- MEASURE, rise with MIN_PERIOD≤cnt≤MAX_PERIOD:
  - period←cnt, cnt←1, period_valid=1 on the next cycle.
  - tone_id and tone_locked are updated in the same cycle as period_valid.
  - Rises N cycles apart give period==N exactly.
- Simultaneous rise and cnt==MAX_PERIOD: the rise wins and the period is accepted.
- Classification (unsigned |period−Pxx|, computed in 25 bits):
  - Within TOL of P440 → 1; else within TOL of P880 → 2; else 0.
  - The bands do not overlap at default values.
- Lock counter:
  - On each period_valid, if new tone_id≠0 and equals the previous tone_id: lock_cnt saturating-increments to LOCK_COUNT.
  - Otherwise lock_cnt←(tone_id≠0 ? 1 : 0).
  - tone_locked = (lock_cnt==LOCK_COUNT), registered, changing only with period_valid or timeout.
- Reset asserted mid-measurement: immediate return to reset values; the first edge after release is treated as a starting edge.
- No input other than pin_in affects state; there is no software control.

Test Plan:
- Reset release, pin_in 0 for 8.4M cycles → no period_valid, no timeout (IDLE never times out), all outputs 0.
- pin_in square wave, 56818 high / 56818 low, 6 periods → first edge gives signal_present=1; 5 strobes with period=113636, tone_id=1; tone_locked=1 from the 4th strobe onward.
- Half-period 28409 for 3 periods, then switch to 56818 → tone_id=2 on those strobes; when 440 Hz resumes, tone_id=1 and tone_locked=0 until 4 matches.
- Stop toggling after lock → exactly MAX_PERIOD cycles after the last accepted edge: timeout strobe, signal_present=0, tone_locked=0, tone_id=0, period still 113636.
- Glitch: a 3-cycle high pulse 500 cycles after an accepted rise within a 113636 period → ignored; the next strobe reports period=113636.
- Period 120000 (outside ±1136 of 113636) → tone_id=0, lock_cnt cleared; assert rst mid-period → all outputs 0 asynchronously.
